// File: rtl/lane_dly_pkg.sv
// Shared types and encodings for the DQS delay-line command sequencer.
// Optional tap tracking is enabled by defining LANE_DLY_TAP_TRACK_EN.
package lane_dly_pkg;

    localparam int TAP_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ISSUE,
        GAP,
        HOLD,
        RESP
    } state_t;

    localparam logic OP_MOVE = 1'b0;
    localparam logic OP_LOAD = 1'b1;

    localparam logic SEL_RX = 1'b0;
    localparam logic SEL_TX = 1'b1;

endpackage

// File: rtl/lane_dly_tap_tracker.sv
// Saturating up/down/load counter shadowing one delay line's tap position.
// Only instantiated when LANE_DLY_TAP_TRACK_EN is defined.
module lane_dly_tap_tracker
    import lane_dly_pkg::*;
#(
    parameter logic [TAP_W-1:0] LOAD_VAL = 8'd1,
    parameter logic [TAP_W-1:0] MAX_VAL  = 8'd255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             move,
    input  logic             dir,
    output logic [TAP_W-1:0] pos
);

    always_ff @(posedge clk) begin
        if (rst) begin
            pos <= LOAD_VAL;
        end else if (load) begin
            pos <= LOAD_VAL;
        end else if (move) begin
            if (dir) begin
                if (pos < MAX_VAL) pos <= pos + 8'd1;
            end else begin
                if (pos != '0) pos <= pos - 8'd1;
            end
        end
    end

endmodule

// File: rtl/lane_dly_cmd_seq.sv
// DQS delay-line command sequencer: pause window, LOAD/MOVE pulses, OOR abort.
// Define LANE_DLY_TAP_TRACK_EN to build the RX/TX tap position trackers.
module lane_dly_cmd_seq
    import lane_dly_pkg::*;
#(
    parameter int               PAUSE_SETUP  = 4,
    parameter int               PAUSE_HOLD   = 4,
    parameter int               MOVE_GAP     = 3,
    parameter logic [TAP_W-1:0] TAP_LOAD_VAL = 8'd1,
    parameter logic [TAP_W-1:0] TAP_MAX      = 8'd255
) (
    input  logic             FAB_CLK,
    input  logic             RESET,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic             CMD_SEL,
    input  logic             CMD_OP,
    input  logic             CMD_DIR,
    input  logic [TAP_W-1:0] CMD_TAPS,
    output logic             RSP_VALID,
    input  logic             RSP_READY,
    output logic             RSP_OOR,
    output logic [TAP_W-1:0] RSP_TAPS,
    output logic             BUSY,
    output logic             DELAY_LINE_SEL,
    output logic             DELAY_LINE_LOAD,
    output logic             DELAY_LINE_DIRECTION,
    output logic             DELAY_LINE_MOVE,
    output logic             HS_IO_CLK_PAUSE,
    input  logic             RX_DELAY_LINE_OUT_OF_RANGE,
    input  logic             TX_DELAY_LINE_OUT_OF_RANGE,
    output logic [TAP_W-1:0] RX_TAP_POS,
    output logic [TAP_W-1:0] TX_TAP_POS
);

    localparam logic [7:0] SETUP_LAST = 8'(PAUSE_SETUP - 1);
    localparam logic [7:0] GAP_LAST   = 8'(MOVE_GAP - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(PAUSE_HOLD - 1);

    state_t           state;
    state_t           nxt;
    logic [7:0]       cnt;
    logic [TAP_W-1:0] rem;
    logic             op_q;
    logic             accept;
    logic             abort;
    logic             oor_flag;
    logic             issue_nxt;

    // Selected line's flag; SEL is latched at accept so it is stable here.
    assign oor_flag  = DELAY_LINE_SEL ? TX_DELAY_LINE_OUT_OF_RANGE
                                      : RX_DELAY_LINE_OUT_OF_RANGE;
    assign accept    = (state == IDLE) && CMD_VALID && CMD_READY;
    assign abort     = (state == GAP) && (cnt == GAP_LAST) && oor_flag;
    assign issue_nxt = (nxt == ISSUE);

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) nxt = SETUP;
            end
            SETUP: begin
                if (cnt == SETUP_LAST)
                    nxt = (op_q == OP_LOAD || rem != '0) ? ISSUE : HOLD;
            end
            ISSUE: begin
                nxt = GAP;
            end
            GAP: begin
                if (cnt == GAP_LAST)
                    nxt = (oor_flag || rem == '0) ? HOLD : ISSUE;
            end
            HOLD: begin
                if (cnt == HOLD_LAST) nxt = RESP;
            end
            RESP: begin
                if (RSP_READY) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge FAB_CLK) begin
        if (RESET) begin
            state                <= IDLE;
            cnt                  <= '0;
            rem                  <= '0;
            op_q                 <= OP_MOVE;
            CMD_READY            <= 1'b0;
            BUSY                 <= 1'b0;
            RSP_VALID            <= 1'b0;
            RSP_OOR              <= 1'b0;
            RSP_TAPS             <= '0;
            DELAY_LINE_SEL       <= 1'b0;
            DELAY_LINE_DIRECTION <= 1'b0;
            DELAY_LINE_LOAD      <= 1'b0;
            DELAY_LINE_MOVE      <= 1'b0;
            HS_IO_CLK_PAUSE      <= 1'b0;
        end else begin
            state     <= nxt;
            cnt       <= (nxt != state) ? 8'd0 : cnt + 8'd1;
            CMD_READY <= (nxt == IDLE);
            BUSY      <= (nxt != IDLE);
            RSP_VALID <= (nxt == RESP);
            HS_IO_CLK_PAUSE <= (nxt == SETUP) || (nxt == ISSUE)
                            || (nxt == GAP);
            DELAY_LINE_LOAD <= issue_nxt && (op_q == OP_LOAD);
            DELAY_LINE_MOVE <= issue_nxt && (op_q == OP_MOVE);
            if (accept) begin
                op_q                 <= CMD_OP;
                DELAY_LINE_SEL       <= CMD_SEL;
                DELAY_LINE_DIRECTION <= CMD_DIR;
                rem      <= (CMD_OP == OP_LOAD) ? 8'd1 : CMD_TAPS;
                RSP_OOR  <= 1'b0;
                RSP_TAPS <= '0;
            end
            if (issue_nxt) begin
                rem <= rem - 8'd1;
                if (op_q == OP_MOVE) RSP_TAPS <= RSP_TAPS + 8'd1;
            end
            if (abort) RSP_OOR <= 1'b1;
        end
    end

`ifdef LANE_DLY_TAP_TRACK_EN
    logic trk_load;
    logic trk_move;

    // Trackers step together with the registered pulse they shadow.
    assign trk_load = issue_nxt && (op_q == OP_LOAD);
    assign trk_move = issue_nxt && (op_q == OP_MOVE);

    lane_dly_tap_tracker #(
        .LOAD_VAL (TAP_LOAD_VAL),
        .MAX_VAL  (TAP_MAX)
    ) u_rx_trk (
        .clk  (FAB_CLK),
        .rst  (RESET),
        .load (trk_load && DELAY_LINE_SEL == SEL_RX),
        .move (trk_move && DELAY_LINE_SEL == SEL_RX),
        .dir  (DELAY_LINE_DIRECTION),
        .pos  (RX_TAP_POS)
    );

    lane_dly_tap_tracker #(
        .LOAD_VAL (TAP_LOAD_VAL),
        .MAX_VAL  (TAP_MAX)
    ) u_tx_trk (
        .clk  (FAB_CLK),
        .rst  (RESET),
        .load (trk_load && DELAY_LINE_SEL == SEL_TX),
        .move (trk_move && DELAY_LINE_SEL == SEL_TX),
        .dir  (DELAY_LINE_DIRECTION),
        .pos  (TX_TAP_POS)
    );
`else
    assign RX_TAP_POS = '0;
    assign TX_TAP_POS = '0;
`endif

endmodule

// File: tb/tb_lane_dly_cmd_seq.sv
// Bench for lane_dly_cmd_seq: timeline model checked every cycle plus literals.
// Tracker expectations follow LANE_DLY_TAP_TRACK_EN.
module tb_lane_dly_cmd_seq;

    localparam int PS = 4;
    localparam int PH = 4;
    localparam int G  = 3;
`ifdef LANE_DLY_TAP_TRACK_EN
    localparam int TRK = 1;
`else
    localparam int TRK = 0;
`endif

    logic       clk = 1'b0;
    logic       RESET = 1'b1;
    logic       CMD_VALID = 1'b0;
    logic       CMD_READY;
    logic       CMD_SEL = 1'b0;
    logic       CMD_OP = 1'b0;
    logic       CMD_DIR = 1'b0;
    logic [7:0] CMD_TAPS = 8'd0;
    logic       RSP_VALID;
    logic       RSP_READY = 1'b1;
    logic       RSP_OOR;
    logic [7:0] RSP_TAPS;
    logic       BUSY;
    logic       DL_SEL, DL_LOAD, DL_DIR, DL_MOVE, PAUSE;
    logic       RX_OOR = 1'b0;
    logic       TX_OOR = 1'b0;
    logic [7:0] RX_TAP_POS, TX_TAP_POS;

    always #5 clk = ~clk;

    lane_dly_cmd_seq dut (
        .FAB_CLK                    (clk),
        .RESET                      (RESET),
        .CMD_VALID                  (CMD_VALID),
        .CMD_READY                  (CMD_READY),
        .CMD_SEL                    (CMD_SEL),
        .CMD_OP                     (CMD_OP),
        .CMD_DIR                    (CMD_DIR),
        .CMD_TAPS                   (CMD_TAPS),
        .RSP_VALID                  (RSP_VALID),
        .RSP_READY                  (RSP_READY),
        .RSP_OOR                    (RSP_OOR),
        .RSP_TAPS                   (RSP_TAPS),
        .BUSY                       (BUSY),
        .DELAY_LINE_SEL             (DL_SEL),
        .DELAY_LINE_LOAD            (DL_LOAD),
        .DELAY_LINE_DIRECTION       (DL_DIR),
        .DELAY_LINE_MOVE            (DL_MOVE),
        .HS_IO_CLK_PAUSE            (PAUSE),
        .RX_DELAY_LINE_OUT_OF_RANGE (RX_OOR),
        .TX_DELAY_LINE_OUT_OF_RANGE (TX_OOR),
        .RX_TAP_POS                 (RX_TAP_POS),
        .TX_TAP_POS                 (TX_TAP_POS)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Timeline model: cycle t after accept, pulses at PS+1+j*(1+G).
    bit m_act = 0;
    int m_t = 0;
    int m_n = 0;
    bit m_sel, m_op, m_dir;
    bit e_ready, e_pause, e_move, e_load, e_sel, e_dir, e_busy, e_rv, e_oor;
    int e_rtaps, e_rx, e_tx;
    bit chk_en = 0;

    function automatic int resp_cyc(input int n);
        return 1 + PS + n * (1 + G) + PH;
    endfunction

    always @(posedge clk) begin
        bit pulse;
        int k;
        bit flag;
        chk_en = 1;
        if (RESET) begin
            m_act = 0; e_ready = 0; e_pause = 0; e_move = 0; e_load = 0;
            e_sel = 0; e_dir = 0; e_busy = 0; e_rv = 0; e_oor = 0;
            e_rtaps = 0; e_rx = TRK; e_tx = TRK;
        end else begin
            if (!m_act) begin
                if (CMD_VALID && e_ready) begin
                    m_act = 1; m_t = 1;
                    m_sel = CMD_SEL; m_op = CMD_OP; m_dir = CMD_DIR;
                    m_n = CMD_OP ? 1 : int'(CMD_TAPS);
                    e_oor = 0; e_rtaps = 0; e_sel = CMD_SEL; e_dir = CMD_DIR;
                end
            end else begin
                flag = m_sel ? TX_OOR : RX_OOR;
                if (m_t > PS && (m_t - PS) % (1 + G) == 0) begin
                    k = (m_t - PS) / (1 + G);
                    if (k <= m_n && flag) begin
                        m_n = k;
                        e_oor = 1;
                    end
                end
                if (m_t == resp_cyc(m_n)) begin
                    if (RSP_READY) m_act = 0;
                end else begin
                    m_t++;
                end
            end
            pulse = m_act && m_t > PS && m_t <= PS + m_n * (1 + G)
                    && (m_t - PS - 1) % (1 + G) == 0;
            e_pause = m_act && m_t >= 1 && m_t <= PS + m_n * (1 + G);
            e_move  = pulse && !m_op;
            e_load  = pulse && m_op;
            e_busy  = m_act;
            e_ready = !m_act;
            e_rv    = m_act && m_t == resp_cyc(m_n);
            if (e_move) begin
                e_rtaps++;
                if (TRK == 1) begin
                    if (m_sel) e_tx = m_dir ? (e_tx < 255 ? e_tx + 1 : 255)
                                            : (e_tx > 0 ? e_tx - 1 : 0);
                    else       e_rx = m_dir ? (e_rx < 255 ? e_rx + 1 : 255)
                                            : (e_rx > 0 ? e_rx - 1 : 0);
                end
            end
            if (e_load && TRK == 1) begin
                if (m_sel) e_tx = 1;
                else       e_rx = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmd_ready", int'(CMD_READY), int'(e_ready));
            chk("busy", int'(BUSY), int'(e_busy));
            chk("pause", int'(PAUSE), int'(e_pause));
            chk("move", int'(DL_MOVE), int'(e_move));
            chk("load", int'(DL_LOAD), int'(e_load));
            chk("sel", int'(DL_SEL), int'(e_sel));
            chk("dir", int'(DL_DIR), int'(e_dir));
            chk("rsp_valid", int'(RSP_VALID), int'(e_rv));
            chk("rsp_oor", int'(RSP_OOR), int'(e_oor));
            chk("rsp_taps", int'(RSP_TAPS), e_rtaps);
            chk("rx_tap", int'(RX_TAP_POS), e_rx);
            chk("tx_tap", int'(TX_TAP_POS), e_tx);
        end
    end

    // All bench actions happen #1 after a rising edge.
    task automatic send(input logic sel, input logic op, input logic dir,
                        input logic [7:0] taps);
        int w = 0;
        while (!CMD_READY && w < 100) begin
            @(posedge clk); #1; w++;
        end
        if (!CMD_READY) chk("ready_timeout", 0, 1);
        CMD_SEL = sel; CMD_OP = op; CMD_DIR = dir; CMD_TAPS = taps;
        CMD_VALID = 1'b1;
        @(posedge clk); #1;
        CMD_VALID = 1'b0;
    endtask

    // Returns the cycle index (accept edge -> cycle 1) at which RSP_VALID rises.
    task automatic wait_rsp(input int oor_at, output int lat);
        lat = 1;
        while (!RSP_VALID && lat < 300) begin
            @(posedge clk); #1; lat++;
            if (lat == oor_at) RX_OOR = 1'b1;
        end
        if (!RSP_VALID) chk("rsp_timeout", 0, 1);
    endtask

    task automatic run(input string nm, input logic sel, input logic op,
                       input logic dir, input logic [7:0] taps,
                       input int exp_lat, input int exp_taps, input int exp_oor);
        int lat;
        send(sel, op, dir, taps);
        wait_rsp(0, lat);
        chk({nm, "_lat"}, lat, exp_lat);
        chk({nm, "_taps"}, int'(RSP_TAPS), exp_taps);
        chk({nm, "_oor"}, int'(RSP_OOR), exp_oor);
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        repeat (3) @(posedge clk);
        #1;
        chk("ready_in_reset", int'(CMD_READY), 0);
        RESET = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_reset", int'(CMD_READY), 1);
        chk("rx_tap_reset", int'(RX_TAP_POS), TRK * 1);

        run("mv_rx3", 1'b0, 1'b0, 1'b1, 8'd3, 21, 3, 0);
        chk("rx_tap_after_mv3", int'(RX_TAP_POS), TRK * 4);

        run("mv_tx5", 1'b1, 1'b0, 1'b1, 8'd5, 29, 5, 0);
        chk("tx_tap_after_mv5", int'(TX_TAP_POS), TRK * 6);
        run("ld_tx", 1'b1, 1'b1, 1'b0, 8'd9, 13, 0, 0);
        chk("tx_tap_after_ld", int'(TX_TAP_POS), TRK * 1);

        send(1'b0, 1'b0, 1'b1, 8'd10);
        wait_rsp(10, lat);
        chk("oor_lat", lat, 17);
        chk("oor_taps", int'(RSP_TAPS), 2);
        chk("oor_flag", int'(RSP_OOR), 1);
        chk("rx_tap_after_oor", int'(RX_TAP_POS), TRK * 6);
        @(posedge clk); #1;
        RX_OOR = 1'b0;

        run("ld_rx", 1'b0, 1'b1, 1'b1, 8'd0, 13, 0, 0);
        run("mv_rx_dn4", 1'b0, 1'b0, 1'b0, 8'd4, 25, 4, 0);
        chk("rx_tap_floor", int'(RX_TAP_POS), 0);
        run("mv_zero", 1'b0, 1'b0, 1'b1, 8'd0, 9, 0, 0);

        TX_OOR = 1'b1;
        run("oor_preset", 1'b1, 1'b0, 1'b1, 8'd5, 13, 1, 1);
        TX_OOR = 1'b0;
        chk("tx_tap_preset", int'(TX_TAP_POS), TRK * 2);

        RSP_READY = 1'b0;
        send(1'b0, 1'b0, 1'b1, 8'd1);
        wait_rsp(0, lat);
        chk("bp_lat", lat, 13);
        CMD_VALID = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", int'(RSP_VALID), 1);
            chk("bp_ready", int'(CMD_READY), 0);
            chk("bp_taps", int'(RSP_TAPS), 1);
        end
        CMD_VALID = 1'b0;
        RSP_READY = 1'b1;
        @(posedge clk); #1;
        chk("bp_released", int'(RSP_VALID), 0);
        @(posedge clk); #1;
        chk("bp_not_queued", int'(BUSY), 0);

        send(1'b0, 1'b0, 1'b1, 8'd3);
        repeat (5) begin @(posedge clk); #1; end
        chk("rst_pre_busy", int'(BUSY), 1);
        RESET = 1'b1;
        @(posedge clk); #1;
        chk("rst_pause", int'(PAUSE), 0);
        chk("rst_move", int'(DL_MOVE), 0);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_rx_tap", int'(RX_TAP_POS), TRK * 1);
        chk("rst_tx_tap", int'(TX_TAP_POS), TRK * 1);
        RESET = 1'b0;
        repeat (25) begin
            @(posedge clk); #1;
            chk("rst_no_rsp", int'(RSP_VALID), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lane_dly_cmd_seq.md
Name: lane_dly_cmd_seq

Overview:
- Fabric-side initiator for the DDR PHY lane controller's delay-line training port.
- Accepts tap-adjust commands for the RX or TX DQS delay line and drives DELAY_LINE_SEL, DELAY_LINE_LOAD, DELAY_LINE_DIRECTION and DELAY_LINE_MOVE.
- Wraps each command in an HS_IO_CLK_PAUSE window.
- Monitors the lane's out-of-range flags and returns a per-command response to the training controller.

Parameters:
- PAUSE_SETUP, 4: cycles HS_IO_CLK_PAUSE is high before the first LOAD/MOVE pulse.
- PAUSE_HOLD, 4: cycles after the last pulse gap with pause low before the response.
- MOVE_GAP, 3: idle cycles after each LOAD/MOVE pulse.
- TAP_LOAD_VAL, 8'd1: tap position after LOAD and after reset.
- TAP_MAX, 8'd255: tap tracker saturation ceiling.

Ports:
- FAB_CLK  in  1  sole clock.
- RESET  in  1  synchronous, active-high reset.
- CMD_VALID  in  1  command request.
- CMD_READY  out  1  high only in IDLE.
- CMD_SEL  in  1  0=RX DQS line, 1=TX DQS line.
- CMD_OP  in  1  0=MOVE, 1=LOAD.
- CMD_DIR  in  1  1=increment delay, 0=decrement.
- CMD_TAPS  in  8  MOVE pulse count; ignored for LOAD.
- RSP_VALID  out  1  response available.
- RSP_READY  in  1  response accepted.
- RSP_OOR  out  1  command aborted on out-of-range.
- RSP_TAPS  out  8  MOVE pulses actually issued.
- BUSY  out  1  high in every state except IDLE.
- DELAY_LINE_SEL  out  1  to the lane controller.
- DELAY_LINE_LOAD  out  1  to the lane controller.
- DELAY_LINE_DIRECTION  out  1  to the lane controller.
- DELAY_LINE_MOVE  out  1  to the lane controller.
- HS_IO_CLK_PAUSE  out  1  to the lane pause synchroniser.
- RX_DELAY_LINE_OUT_OF_RANGE  in  1  from the lane controller.
- TX_DELAY_LINE_OUT_OF_RANGE  in  1  from the lane controller.
- RX_TAP_POS  out  8  tracked RX tap position (optional feature).
- TX_TAP_POS  out  8  tracked TX tap position (optional feature).

Behaviour:
- All outputs are registered. One clock, FAB_CLK; reset is synchronous and active-high on RESET.
- Reset values: CMD_READY=0 while RESET is high, then 1. RSP_VALID, RSP_OOR, RSP_TAPS, BUSY, all DELAY_LINE_* and HS_IO_CLK_PAUSE = 0. Tap positions = TAP_LOAD_VAL.
- FSM states: IDLE, SETUP, ISSUE, GAP, HOLD, RESP.
- IDLE: CMD_VALID&CMD_READY latches SEL/OP/DIR/TAPS and goes to SETUP. The next cycle HS_IO_CLK_PAUSE=1 and DELAY_LINE_SEL/DIRECTION take the command values. These two stay stable until the state returns to IDLE.
- SETUP: runs PAUSE_SETUP cycles, then:
  - LOAD, or MOVE with TAPS>0 -> ISSUE.
  - MOVE with TAPS=0 -> HOLD.
- ISSUE: exactly one cycle with DELAY_LINE_LOAD=1 (LOAD) or DELAY_LINE_MOVE=1 (MOVE). Decrements the remaining count. Then -> GAP.
- GAP: MOVE_GAP cycles. On the last GAP cycle the selected out-of-range flag is sampled:
  - flag set -> RSP_OOR=1 and -> HOLD (abort).
  - else remaining>0 -> ISSUE.
  - else -> HOLD.
- HOLD: HS_IO_CLK_PAUSE=0 for PAUSE_HOLD cycles, then -> RESP.
- RESP: RSP_VALID=1 with RSP_OOR/RSP_TAPS stable until RSP_READY. Then -> IDLE and RSP_VALID clears the next cycle.
- Latency from the accept edge to RSP_VALID = 1+PAUSE_SETUP+N*(1+MOVE_GAP)+PAUSE_HOLD, where N = number of pulses (LOAD counts as N=1). With defaults: MOVE 3 -> 21 cycles, MOVE 0 -> 9, LOAD -> 13.
- Out-of-range already set at accept: still detected on the first GAP sample, giving RSP_TAPS=1.
- CMD_VALID asserted while BUSY is ignored and not queued.
- RESET mid-command: on the next edge pause and pulses drop to 0, the FSM goes to IDLE and no response is produced.

Optional Feature:
- Macro LANE_DLY_TAP_TRACK_EN.
- Defined: per-line 8-bit tap trackers.
  - LOAD sets the selected tracker to TAP_LOAD_VAL.
  - Each MOVE pulse increments (DIR=1) or decrements it, saturating at TAP_MAX and 0.
  - Trackers update in the ISSUE cycle.
- Undefined: RX_TAP_POS and TX_TAP_POS are tied to 0 and no tracker registers exist.

Decomposition:
- Package lane_dly_pkg holds:
  - state enum (IDLE..RESP);
  - op encodings (OP_MOVE=0, OP_LOAD=1);
  - sel encodings (SEL_RX=0, SEL_TX=1);
  - tap width constant 8.
- One sub-module, lane_dly_tap_tracker (a single saturating up/down/load counter), instantiated twice under LANE_DLY_TAP_TRACK_EN.

Test Plan:
- Reset, then MOVE RX DIR=1 TAPS=3 -> 3 MOVE pulses at cycles 5, 9, 13 after accept; PAUSE high for cycles 1..16; RSP_VALID at cycle 21; RSP_TAPS=3, RSP_OOR=0; RX_TAP_POS=4.
- LOAD TX after a TX MOVE of 5 -> single LOAD pulse at cycle 5 with SEL=1; TX_TAP_POS=1; RSP_VALID at cycle 13.
- MOVE RX TAPS=10 with RX_DELAY_LINE_OUT_OF_RANGE raised after the 2nd pulse -> abort; RSP_OOR=1, RSP_TAPS=2; pause low within 1 cycle of the sample.
- MOVE DIR=0 TAPS=4 from position 1 -> tracker saturates at 0; MOVE with TAPS=0 -> no pulses, RSP at cycle 9.
- RSP_READY held low for 7 cycles -> RSP_VALID and data stable, CMD_READY=0; a new CMD_VALID during that time is not accepted.
- RESET asserted mid-GAP -> next edge PAUSE=0, MOVE=0, BUSY=0, trackers=1, no RSP_VALID.
